// File: rtl/cam_config_seq.sv
// rtl/cam_config_seq.sv - camera register table sequencer feeding an SCCB write master
// Walks a {reg,val} ROM table per mode, issuing writes with NACK retry and 0xFE delay entries.
module cam_config_seq #(
  parameter int IDX_W     = 6,
  parameter int MODE_W    = 2,
  parameter int DELAY_CYC = 25000,
  parameter int MAX_RETRY = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_start,
  input  logic [MODE_W-1:0]       i_mode,
  output logic [MODE_W+IDX_W-1:0] o_rom_addr,
  input  logic [15:0]             i_rom_data,
  output logic                    o_wr_valid,
  output logic [7:0]              o_wr_addr,
  output logic [7:0]              o_wr_data,
  input  logic                    i_wr_ready,
  input  logic                    i_xfer_done,
  input  logic                    i_xfer_nack,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  output logic [IDX_W-1:0]        o_index
);

  localparam int PRE_W   = $clog2(DELAY_CYC + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t                    state_q, state_d;
  logic [MODE_W-1:0]         mode_q, mode_d;
  logic [IDX_W-1:0]          index_q, index_d, index_nxt;
  logic [RETRY_W-1:0]        retry_q, retry_d;
  logic [MODE_W+IDX_W-1:0]   rom_addr_q, rom_addr_d;
  logic [7:0]                wr_addr_q, wr_addr_d;
  logic [7:0]                wr_data_q, wr_data_d;
  logic [PRE_W-1:0]          pre_q, pre_d;
  logic [7:0]                unit_q, unit_d;
  logic                      adv;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      index_q    <= '0;
      retry_q    <= '0;
      rom_addr_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      pre_q      <= '0;
      unit_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      index_q    <= index_d;
      retry_q    <= retry_d;
      rom_addr_q <= rom_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      pre_q      <= pre_d;
      unit_q     <= unit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    index_d    = index_q;
    retry_d    = retry_q;
    rom_addr_d = rom_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    pre_d      = pre_q;
    unit_d     = unit_q;
    adv        = 1'b0;
    index_nxt  = index_q + IDX_W'(1);

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          mode_d     = i_mode;
          index_d    = '0;
          retry_d    = '0;
          rom_addr_d = {i_mode, {IDX_W{1'b0}}};
          state_d    = S_FETCH;
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (i_rom_data == 16'hFFFF) begin
          state_d = S_DONE;
        end else if (i_rom_data[15:8] == 8'hFE) begin
          if (i_rom_data[7:0] == 8'd0) begin
            adv = 1'b1;
          end else begin
            unit_d  = i_rom_data[7:0];
            pre_d   = '0;
            state_d = S_DELAY;
          end
        end else begin
          wr_addr_d = i_rom_data[15:8];
          wr_data_d = i_rom_data[7:0];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: if (i_wr_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (i_xfer_done) begin
          if (!i_xfer_nack) begin
            adv = 1'b1;
          end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = S_ISSUE;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_DELAY: begin
        // prescaler wraps once per unit; the last unit's wrap ends the delay
        if (pre_q == PRE_W'(DELAY_CYC - 1)) begin
          pre_d = '0;
          if (unit_q == 8'd1) adv = 1'b1;
          else                unit_d = unit_q - 8'd1;
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      retry_d = '0;
      if (index_q == {IDX_W{1'b1}}) begin
        state_d = S_DONE;
      end else begin
        index_d    = index_nxt;
        rom_addr_d = {mode_q, index_nxt};
        state_d    = S_FETCH;
      end
    end
  end

  assign o_rom_addr = rom_addr_q;
  assign o_wr_valid = (state_q == S_ISSUE);
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_busy     = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
  assign o_done     = (state_q == S_DONE);
  assign o_error    = (state_q == S_ERROR);
  assign o_index    = index_q;

endmodule

// File: doc/cam_config_seq.md
CAM_CONFIG_SEQ -- requirements
Module: cam_config_seq

Interface
REQ-001 Parameter IDX_W, default 6, means the entry index width; each mode table holds 2^IDX_W entries.
REQ-002 Parameter MODE_W, default 2, means the mode-select width; up to 2^MODE_W tables are supported.
REQ-003 Parameter DELAY_CYC, default 25000, means the number of clock cycles per delay unit (1 ms at 25 MHz).
REQ-004 Parameter MAX_RETRY, default 3, means the number of NACK retries per entry before the block errors.
REQ-005 Port i_clk, input, 1 bit, is the single clock; all logic is on its rising edge.
REQ-006 Port i_rstn, input, 1 bit, is the reset: synchronous and active-low.
REQ-007 Port i_start, input, 1 bit, is a 1-cycle configuration start pulse.
REQ-008 Port i_mode, input, MODE_W bits, selects the table and is sampled at start.
REQ-009 Port o_rom_addr, output, MODE_W+IDX_W bits, is the table ROM address {mode, index}; it is registered.
REQ-010 Port i_rom_data, input, 16 bits, is the ROM word {reg[15:8], val[7:0]}, valid 1 cycle after o_rom_addr changes.
REQ-011 Port o_wr_valid, input/output direction output, 1 bit, is the register-write request to the SCCB master.
REQ-012 Ports o_wr_addr and o_wr_data, outputs, 8 bits each, carry the register address and value.
REQ-013 Port i_wr_ready, input, 1 bit, is the SCCB master accept signal.
REQ-014 Port i_xfer_done, input, 1 bit, is a 1-cycle pulse marking transfer completion; i_xfer_nack (input, 1 bit) is valid with it.
REQ-015 Ports o_busy, o_done and o_error are 1-bit status outputs; o_index (IDX_W bits) is the current entry.

Function
REQ-016 The block SHALL use the states IDLE, FETCH, DECODE, ISSUE, WAIT, DELAY, DONE and ERROR.
REQ-017 i_start in IDLE, DONE or ERROR SHALL:
- latch i_mode;
- set index=0 and retry=0;
- clear o_done and o_error;
- drive o_rom_addr={mode,0};
- enter FETCH.
REQ-018 i_start in any other state SHALL be ignored, and i_mode changes mid-run SHALL have no effect.
REQ-019 FETCH SHALL last exactly 1 cycle; DECODE SHALL sample i_rom_data in the following cycle.
REQ-020 In DECODE:
- word 16'hFFFF -> DONE;
- reg==8'hFE -> DELAY for val units;
- otherwise load o_wr_addr=reg and o_wr_data=val and enter ISSUE.
REQ-021 A delay entry with val==0 SHALL advance immediately with no delay cycles.
REQ-022 In ISSUE, o_wr_valid=1 SHALL be held, with addr/data stable, until the cycle i_wr_ready=1; that cycle is the handshake, and o_wr_valid SHALL be 0 the next cycle, in WAIT.
REQ-023 Start-to-first-o_wr_valid latency SHALL be 3 cycles: start at cycle 0, FETCH at 1, DECODE at 2, ISSUE at 3.
REQ-024 In WAIT, i_xfer_done with nack=0 SHALL advance.
REQ-025 In WAIT, i_xfer_done with nack=1 and retry<MAX_RETRY SHALL increment retry and re-enter ISSUE with the same entry.
REQ-026 In WAIT, i_xfer_done with nack=1 and retry==MAX_RETRY SHALL enter ERROR.
REQ-027 i_xfer_done outside WAIT SHALL be ignored.
REQ-028 DELAY SHALL use a prescaler counting DELAY_CYC cycles per unit plus an 8-bit unit counter, giving a total of val*DELAY_CYC cycles (±1).
REQ-029 Advance SHALL:
- clear retry;
- if index==2^IDX_W-1, enter DONE (table exhausted without terminator, no wrap);
- else index+1, update o_rom_addr, enter FETCH.
REQ-030 o_busy SHALL be 1 in every state except IDLE, DONE and ERROR.
REQ-031 o_done SHALL be 1 only in DONE and o_error only in ERROR, each held until the next start or reset.
REQ-032 o_index SHALL equal the current index; in ERROR it SHALL hold the failing entry.
REQ-033 i_start and i_xfer_done in the same cycle in DONE SHALL start a new run; the done pulse SHALL be ignored.

Reset
REQ-034 With i_rstn=0 at a clock edge, the block SHALL enter IDLE and clear index, retry, both delay counters and the latched mode.
REQ-035 Under reset, every output SHALL be 0: o_rom_addr, o_wr_valid, o_wr_addr, o_wr_data, o_busy, o_done, o_error, o_index.
REQ-036 Reset mid-run, including ISSUE with o_wr_valid=1, SHALL drop o_wr_valid on the next cycle, with no further requests until a new i_start.
REQ-037 i_start coincident with i_rstn=0 SHALL be ignored.

Verification
REQ-038 Mode 1 table {12_80, 11_80, FFFF}, ready and done immediate, nack=0 -> exactly 2 writes (12/80, 11/80) -> o_done=1, o_busy=0, o_index=2.
REQ-039 Entry FE_02 with DELAY_CYC=10 -> no write issued; next FETCH follows 20±1 cycles after DECODE.
REQ-040 NACK on entry 3 for 4 consecutive attempts (MAX_RETRY=3) -> 4 ISSUE handshakes, then o_error=1, o_index=3, o_busy=0.
REQ-041 i_wr_ready held low 50 cycles -> o_wr_valid stays 1 with o_wr_addr/o_wr_data constant; i_start pulses meanwhile have no effect.
REQ-042 IDX_W=2, table with no FFFF -> 4 writes, then o_done=1 with o_index=3 and no index wrap.
REQ-043 i_rstn=0 during ISSUE -> o_wr_valid=0 the next cycle and all outputs 0; a following i_start restarts at index 0.
